// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control sequencer: states, opcodes,
// condition-vector indices and flag bit positions.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StHalt   = 3'd5
   } state_e;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_ALU    = 3'd1;
   localparam logic [2:0] OP_CMP    = 3'd2;
   localparam logic [2:0] OP_LOAD   = 3'd3;
   localparam logic [2:0] OP_STORE  = 3'd4;
   localparam logic [2:0] OP_BRANCH = 3'd5;
   localparam logic [2:0] OP_HALT   = 3'd6;

   localparam int unsigned COND_ALWAYS = 0;
   localparam int unsigned COND_Z      = 1;
   localparam int unsigned COND_NZ     = 2;
   localparam int unsigned COND_N      = 3;
   localparam int unsigned COND_NN     = 4;
   localparam int unsigned COND_C      = 5;
   localparam int unsigned COND_NC     = 6;
   localparam int unsigned COND_V      = 7;
   localparam int unsigned COND_NV     = 8;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/cond_eval.sv
// Status-flag register, 9-entry condition vector and branch-taken select.
// Condition codes above COND_NV are never taken.
module cond_eval
   import cpu_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       flag_we_i,
   input  logic [3:0] alu_flags_i,
   input  logic [3:0] cond_i,
   output logic [8:0] cond_vec_o,
   output logic       taken_o
);

   logic [3:0]  flags_d, flags_q;
   logic [15:0] cond_ext;

   always_comb begin
      flags_d = flag_we_i ? alu_flags_i : flags_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= 4'b0000;
      end else begin
         flags_q <= flags_d;
      end
   end

   always_comb begin
      cond_vec_o              = '0;
      cond_vec_o[COND_ALWAYS] = 1'b1;
      cond_vec_o[COND_Z]      = flags_q[FLAG_Z];
      cond_vec_o[COND_NZ]     = ~flags_q[FLAG_Z];
      cond_vec_o[COND_N]      = flags_q[FLAG_N];
      cond_vec_o[COND_NN]     = ~flags_q[FLAG_N];
      cond_vec_o[COND_C]      = flags_q[FLAG_C];
      cond_vec_o[COND_NC]     = ~flags_q[FLAG_C];
      cond_vec_o[COND_V]      = flags_q[FLAG_V];
      cond_vec_o[COND_NV]     = ~flags_q[FLAG_V];
   end

   always_comb begin
      cond_ext = {7'd0, cond_vec_o};
      taken_o  = (cond_i <= 4'(COND_NV)) ? cond_ext[cond_i] : 1'b0;
   end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Define MEM_TIMEOUT_EN to bound memory waits by TIMEOUT_CYCLES and report bus_err.
module cpu_control_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W       = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] instr_opcode,
   input  logic [3:0]          instr_cond,
   input  logic [3:0]          alu_flags,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                ir_we,
   output logic                pc_we,
   output logic                pc_src,
   output logic                reg_we,
   output logic                flag_we,
   output logic [8:0]          cond_vec,
   output logic [2:0]          state,
   output logic                halted,
   output logic                illegal,
   output logic                bus_err
);

   state_e     state_d, state_q;
   logic       illegal_d, illegal_q;
   logic [2:0] op;
   logic       legal;
   logic       branch_taken;

   assign op    = instr_opcode[2:0];
   assign legal = (instr_opcode <= OPCODE_W'(OP_HALT));

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] wait_cnt_d, wait_cnt_q;
   logic            bus_err_d, bus_err_q;
   logic            timeout;

   // Fires on the wait cycle that would take the counter to the limit.
   assign timeout = (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) && !mem_ready;
   assign bus_err = bus_err_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign bus_err            = 1'b0;
`endif

   cond_eval u_cond_eval (
      .clk         (clk),
      .rst         (rst),
      .flag_we_i   (flag_we),
      .alu_flags_i (alu_flags),
      .cond_i      (instr_cond),
      .cond_vec_o  (cond_vec),
      .taken_o     (branch_taken)
   );

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 1'b0;
      reg_we    = 1'b0;
      flag_we   = 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err_d  = bus_err_q;
      wait_cnt_d = wait_cnt_q;
`endif
      case (state_q)
         StFetch: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = StDecode;
            end
`ifdef MEM_TIMEOUT_EN
            else if (timeout) begin
               state_d   = StHalt;
               bus_err_d = 1'b1;
            end
`endif
         end
         StDecode: begin
            if (!legal) begin
               state_d   = StHalt;
               illegal_d = 1'b1;
            end else if (op == OP_HALT) begin
               state_d = StHalt;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            case (op)
               OP_NOP: state_d = StFetch;
               OP_ALU: begin
                  flag_we = 1'b1;
                  state_d = StWb;
               end
               OP_CMP: begin
                  flag_we = 1'b1;
                  state_d = StFetch;
               end
               OP_LOAD, OP_STORE: state_d = StMem;
               OP_BRANCH: begin
                  pc_we   = branch_taken;
                  pc_src  = branch_taken;
                  state_d = StFetch;
               end
               default: state_d = StFetch;
            endcase
         end
         StMem: begin
            mem_req = 1'b1;
            mem_we  = (op == OP_STORE);
            if (mem_ready) begin
               state_d = (op == OP_LOAD) ? StWb : StFetch;
            end
`ifdef MEM_TIMEOUT_EN
            else if (timeout) begin
               state_d   = StHalt;
               bus_err_d = 1'b1;
            end
`endif
         end
         StWb: begin
            reg_we  = 1'b1;
            state_d = StFetch;
         end
         StHalt: state_d = StHalt;
         default: state_d = StFetch;
      endcase
`ifdef MEM_TIMEOUT_EN
      if (state_d != state_q) begin
         wait_cnt_d = '0;
      end else if (mem_req && !mem_ready) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
`endif
      if (rst) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
         ir_we   = 1'b0;
         pc_we   = 1'b0;
         pc_src  = 1'b0;
         reg_we  = 1'b0;
         flag_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StFetch;
         illegal_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         bus_err_q  <= 1'b0;
         wait_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         illegal_q  <= illegal_d;
`ifdef MEM_TIMEOUT_EN
         bus_err_q  <= bus_err_d;
         wait_cnt_q <= wait_cnt_d;
`endif
      end
   end

   assign state   = state_q;
   assign halted  = (state_q == StHalt);
   assign illegal = illegal_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench: an instruction-level model expands each directed instruction
// into its expected per-cycle outputs; one process compares the DUT every cycle.
module tb_cpu_control_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] instr_opcode = 4'd0;
   logic [3:0] instr_cond   = 4'd0;
   logic [3:0] alu_flags    = 4'd0;
   logic       mem_ready    = 1'b0;
   logic       mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, flag_we;
   logic [8:0] cond_vec;
   logic [2:0] state;
   logic       halted, illegal, bus_err;

   always #5 clk = ~clk;

   cpu_control_fsm #(
      .OPCODE_W       (4),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .instr_opcode (instr_opcode),
      .instr_cond   (instr_cond),
      .alu_flags    (alu_flags),
      .mem_ready    (mem_ready),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .pc_src       (pc_src),
      .reg_we       (reg_we),
      .flag_we      (flag_we),
      .cond_vec     (cond_vec),
      .state        (state),
      .halted       (halted),
      .illegal      (illegal),
      .bus_err      (bus_err)
   );

   typedef struct {
      bit       rst;
      bit [3:0] op;
      bit [3:0] cond;
      bit [3:0] flags;
      bit       ready;
      bit       full;
      bit [2:0] st;
      bit       mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, flag_we;
      bit [8:0] cv;
      bit       halted, illegal, bus_err;
      bit       lit_en;
      bit [8:0] lit_cv;
   } cyc_t;

   cyc_t     plan[$];
   cyc_t     c;
   bit [3:0] m_flags = 4'd0;
   bit       m_illegal = 1'b0, m_halted = 1'b0, m_bus_err = 1'b0;
   bit [3:0] cur_op = 4'd0, cur_cond = 4'd0, cur_flags = 4'd0;
   bit       pend_en = 1'b0;
   bit [8:0] pend_cv = 9'd0;
   int       n_checks = 0;
   int       n_err = 0;
   int       cyc = 0;
   bit       active = 1'b0;

   // Condition vector straight from the flag meanings: always, then each flag and its inverse.
   function automatic bit [8:0] cv_of(input bit [3:0] f);
      bit z, n, cy, v;
      z = f[0]; n = f[1]; cy = f[2]; v = f[3];
      return {!v, v, !cy, cy, !n, n, !z, z, 1'b1};
   endfunction

   task automatic begin_cyc(input bit [2:0] st);
      c.rst = 0; c.op = cur_op; c.cond = cur_cond; c.flags = cur_flags; c.ready = 1;
      c.full = 1; c.st = st;
      c.mem_req = 0; c.mem_we = 0; c.ir_we = 0; c.pc_we = 0; c.pc_src = 0;
      c.reg_we = 0; c.flag_we = 0;
      c.cv = cv_of(m_flags); c.halted = m_halted; c.illegal = m_illegal; c.bus_err = m_bus_err;
      c.lit_en = pend_en; c.lit_cv = pend_cv; pend_en = 0;
   endtask

   task automatic push();
      plan.push_back(c);
   endtask

   task automatic pin_cv(input bit [8:0] v);
      pend_en = 1; pend_cv = v;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         begin_cyc(3'd0); c.rst = 1; c.full = 0; push();
      end
      m_flags = 4'd0; m_illegal = 0; m_halted = 0; m_bus_err = 0;
   endtask

   task automatic halt_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         begin_cyc(3'd5); push();
      end
   endtask

   task automatic instr(input int op, input int cond, input bit [3:0] flags,
                        input int fwait, input int mwait, input bit abort);
      bit [8:0] cv;
      bit       taken;
      cur_op = 4'(op); cur_cond = 4'(cond); cur_flags = flags;
      for (int w = 0; w < fwait; w++) begin
         begin_cyc(3'd0); c.ready = 0; c.mem_req = 1; push();
      end
      begin_cyc(3'd0); c.mem_req = 1; c.ir_we = 1; c.pc_we = 1; push();
      begin_cyc(3'd1); c.ready = 0; push();
      if (op > 6) begin
         m_illegal = 1; m_halted = 1; return;
      end
      if (op == 6) begin
         m_halted = 1; return;
      end
      begin_cyc(3'd2);
      if (op == 5) begin
         cv = cv_of(m_flags);
         taken = (cond <= 8) ? cv[cond] : 1'b0;
         c.flags = ~m_flags;  // a same-cycle bypass of alu_flags would flip the outcome
         c.pc_we = taken; c.pc_src = taken; push();
         return;
      end
      if (op == 1 || op == 2) begin
         c.flag_we = 1; push();
         m_flags = flags;
         if (op == 1) begin
            begin_cyc(3'd4); c.reg_we = 1; push();
         end
         return;
      end
      if (op == 0) begin
         c.ready = 0; push(); return;
      end
      push();
      for (int w = 0; w < mwait; w++) begin
         begin_cyc(3'd3); c.ready = 0; c.mem_req = 1; c.mem_we = (op == 4); push();
      end
      if (abort) begin
         do_reset(1); return;
      end
      begin_cyc(3'd3); c.mem_req = 1; c.mem_we = (op == 4); push();
      if (op == 3) begin
         begin_cyc(3'd4); c.reg_we = 1; push();
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (active) begin
         cyc_t e;
         e = plan[cyc];
         chk("ir_we", 32'(ir_we), 32'(e.ir_we));
         chk("pc_we", 32'(pc_we), 32'(e.pc_we));
         chk("reg_we", 32'(reg_we), 32'(e.reg_we));
         chk("flag_we", 32'(flag_we), 32'(e.flag_we));
         if (e.full) begin
            chk("state", 32'(state), 32'(e.st));
            chk("mem_req", 32'(mem_req), 32'(e.mem_req));
            chk("cond_vec", 32'(cond_vec), 32'(e.cv));
            chk("halted", 32'(halted), 32'(e.halted));
            chk("illegal", 32'(illegal), 32'(e.illegal));
            chk("bus_err", 32'(bus_err), 32'(e.bus_err));
            if (e.pc_we) chk("pc_src", 32'(pc_src), 32'(e.pc_src));
            if (e.mem_req) chk("mem_we", 32'(mem_we), 32'(e.mem_we));
         end else begin
            chk("mem_we_rst", 32'(mem_we), 32'(0));
         end
         if (e.lit_en) chk("cond_vec_literal", 32'(cond_vec), 32'(e.lit_cv));
      end
   end

   initial begin
      do_reset(2);
      pin_cv(9'h155);
      instr(0, 0, 4'h0, 0, 0, 0);
      instr(0, 0, 4'hF, 1, 0, 0);
      instr(1, 0, 4'b0001, 0, 0, 0);
      pin_cv(9'h153);
      instr(5, 1, 4'h0, 0, 0, 0);
      instr(2, 0, 4'b0000, 0, 0, 0);
      pin_cv(9'h155);
      instr(5, 1, 4'h0, 0, 0, 0);
      instr(5, 12, 4'h0, 0, 0, 0);
      instr(5, 0, 4'h0, 0, 0, 0);
      instr(5, 2, 4'h0, 0, 0, 0);
      instr(2, 0, 4'b1010, 0, 0, 0);
      pin_cv(9'h0cd);
      instr(5, 8, 4'h0, 0, 0, 0);
      instr(5, 7, 4'h0, 0, 0, 0);
      instr(5, 3, 4'h0, 0, 0, 0);
      instr(3, 0, 4'hF, 2, 3, 0);
      instr(4, 0, 4'h5, 0, 3, 0);
      instr(1, 0, 4'b0110, 0, 0, 0);
      instr(5, 5, 4'h0, 0, 0, 0);
      instr(3, 0, 4'h0, 0, 2, 1);
      instr(0, 0, 4'h0, 0, 0, 0);
      instr(9, 0, 4'h0, 0, 0, 0);
      halt_cycles(10);
      do_reset(1);
      instr(0, 0, 4'h0, 0, 0, 0);
      instr(6, 0, 4'h0, 0, 0, 0);
      halt_cycles(3);
      do_reset(1);
      instr(15, 0, 4'h0, 0, 0, 0);
      halt_cycles(2);
      do_reset(1);
`ifdef MEM_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         begin_cyc(3'd0); c.ready = 0; c.mem_req = 1; push();
      end
      m_bus_err = 1; m_halted = 1;
      halt_cycles(5);
      do_reset(1);
      instr(0, 0, 4'h0, 3, 0, 0);
      instr(3, 0, 4'h0, 3, 3, 0);
      instr(4, 0, 4'h0, 0, 3, 0);
`else
      instr(0, 0, 4'h0, 10, 0, 0);
      instr(4, 0, 4'h0, 0, 12, 0);
`endif
      instr(0, 0, 4'h0, 0, 0, 0);

      for (int i = 0; i < plan.size(); i++) begin
         @(posedge clk);
         #1;
         rst          = plan[i].rst;
         instr_opcode = plan[i].op;
         instr_cond   = plan[i].cond;
         alu_flags    = plan[i].flags;
         mem_ready    = plan[i].ready;
         cyc          = i;
         active       = 1'b1;
      end
      @(posedge clk);
      #1;
      active = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle CPU control sequencer.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Owns the status-flag register (Z,N,C,V) and its write enable, and derives the 9-entry condition vector from it.
- Resolves conditional branches from that vector.
- Handshakes with the unified memory port for instruction fetch and load/store.

Parameters:
- OPCODE_W, 4, opcode field width.
- TIMEOUT_CYCLES, 255, max wait cycles on mem_ready; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_opcode  in  OPCODE_W  opcode from instruction register; valid from DECODE onward.
- instr_cond  in  4  branch condition code; index into the condition vector.
- alu_flags  in  4  {V,C,N,Z} (bit0=Z, bit1=N, bit2=C, bit3=V) from ALU, valid in EXEC.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held high until mem_ready.
- mem_we  out  1  store request, qualified by mem_req.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC update.
- pc_src  out  1  0 = PC+1, 1 = branch target; meaningful only with pc_we.
- reg_we  out  1  register-file write.
- flag_we  out  1  flag register capture strobe (also exported).
- cond_vec  out  9  [0]=1, [1]=Z, [2]=~Z, [3]=N, [4]=~N, [5]=C, [6]=~C, [7]=V, [8]=~V.
- state  out  3  current state encoding, for debug.
- halted  out  1  in HALT.
- illegal  out  1  sticky; illegal opcode seen.
- bus_err  out  1  sticky; memory timeout (0 when feature off).

Behaviour:

Reset:
- state=FETCH, flags=0000, so cond_vec=9'b1_0101_0101 (bits 0,2,4,6,8 high).
- halted=0, illegal=0, bus_err=0.
- All strobes 0 in the reset cycle.
- Reset mid-instruction abandons it; mem_req drops the next cycle.

Opcodes:
- 0 NOP, 1 ALU, 2 CMP, 3 LOAD, 4 STORE, 5 BRANCH, 6 HALT.
- 7..15 illegal.

States:
- FETCH (0): mem_req=1, mem_we=0. On mem_ready: ir_we=1, pc_we=1, pc_src=0, then DECODE. Otherwise stay.
- DECODE (1): no strobes. Opcodes 0-5 go to EXEC; opcode 6 goes to HALT; illegal opcodes go to HALT and set illegal=1.
- EXEC (2), by opcode:
  - NOP: go to FETCH.
  - ALU: flag_we=1, go to WB.
  - CMP: flag_we=1, go to FETCH.
  - LOAD/STORE: go to MEM.
  - BRANCH: taken = (instr_cond<=8) ? cond_vec[instr_cond] : 0. If taken, pc_we=1 and pc_src=1. Go to FETCH.
- MEM (3): mem_req=1, mem_we=(opcode==STORE). On mem_ready, LOAD goes to WB and STORE goes to FETCH.
- WB (4): reg_we=1, go to FETCH.
- HALT (5): all strobes 0; stay until rst. halted=1.

Flags and branch timing:
- Flags capture alu_flags at the clock edge ending an EXEC cycle with flag_we=1.
- A branch evaluates the registered flags only, i.e. the flags of the last flag-setting instruction. There is no same-cycle bypass.

Timing:
- Minimum latencies with mem_ready already high: NOP/CMP/BRANCH 3 cycles; ALU/STORE 4; LOAD 5.

Invariants:
- Strobes are one-hot per cycle except the FETCH pair (ir_we with pc_we).
- mem_req stays stable while mem_ready is low.
- mem_ready outside FETCH/MEM is ignored.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 and mem_ready=0.
  - When the counter reaches TIMEOUT_CYCLES with mem_ready still 0, go to HALT and set bus_err=1 (sticky until rst).
  - mem_ready arriving in the same cycle the counter hits the limit wins; no error.
- Undefined: wait forever; bus_err tied to 0; no counter logic.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encoding constants (FETCH..HALT);
  - opcode constants;
  - condition-vector indices (COND_ALWAYS=0 .. COND_NV=8);
  - flag bit positions (FLAG_Z=0 .. FLAG_V=3).
- One sub-module, cond_eval, holds:
  - the 4-bit flag register with write enable and synchronous reset;
  - the 9-bit cond_vec generation;
  - the taken mux with out-of-range guard.
- FSM and strobe decode stay in cpu_control_fsm.

Test Plan:
1. Reset, mem_ready=1, stream NOP,NOP: state sequence 0,1,2,0,1,2; pc_we pulses every 3 cycles; cond_vec=9'h155.
2. ALU with alu_flags=4'b0001, then BRANCH cond=1: ALU takes 4 cycles with flag_we in EXEC and reg_we in WB; branch is taken (pc_we=1, pc_src=1), cond_vec[1]=1, cond_vec[2]=0.
3. CMP with flags=0000, then BRANCH cond=1 → not taken (no pc_we in EXEC). Then BRANCH cond=12 → not taken. Then BRANCH cond=0 → taken.
4. LOAD with mem_ready low 3 cycles in MEM: mem_req held 4 cycles, mem_we=0, reg_we one cycle after ready; same test with STORE gives mem_we=1 and no reg_we.
5. Opcode 9 in DECODE: next state HALT, illegal=1, halted=1, no strobes for 10 cycles; rst returns to FETCH with illegal=0.
6. MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH → HALT and bus_err=1 after 4 wait cycles; a repeat with ready on cycle 4 gives no error and proceeds to DECODE.
